pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central hazard and redirect controller for the five-stage RV32I pipeline. Collects stall requests from IF, ID (load-use) and MEM plus taken-branch/jump notifications from EX. Drives per-stage stall and clear enables into the pipeline registers (pc_reg, if_id, id_ex, ex_mem, mem_wb). Sequences PC redirection, deferring it while a multi-cycle instruction fetch is in flight.

## Interface
- RESET_PC, 32'h0000_0000, value driven on redirect_pc while in reset and after it.
- clk  in  1  pipeline clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- if_stallreq  in  1  fetch unit has not finished the current instruction.
- id_stallreq  in  1  load-use hazard detected in ID.
- mem_stallreq  in  1  memory access in progress in MEM.
- ex_branch  in  1  EX resolves a taken branch/jump this cycle.
- ex_branch_target  in  32  target PC; valid when ex_branch=1.
- stall  out  5  bit0 pc_reg, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb; 1 = hold.
- clear  out  5  same bit order; 1 = load bubble (zero). Clear overrides stall at the register.
- redirect_valid  out  1  pc_reg must load redirect_pc this cycle, regardless of stall[0].
- redirect_pc  out  32  redirect target.
- stall_cycles  out  32  (only with PIPE_CTRL_PERF_EN) cycles with any stall bit set.
- flush_count  out  32  (only with PIPE_CTRL_PERF_EN) accepted redirects.

## Operation
- FSM: RUN, WAIT_IF, REDIRECT. Registers: state, target (32 bit).
- RUN to WAIT_IF: ex_branch & !mem_stallreq & if_stallreq. Latch target.
- RUN to REDIRECT: ex_branch & !mem_stallreq & !if_stallreq. Latch target.
- WAIT_IF to REDIRECT: !if_stallreq. Stay while if_stallreq=1.
- REDIRECT to RUN: !mem_stallreq. Stay while mem_stallreq=1.
- ex_branch with mem_stallreq=1 is ignored. The branch stays in EX (id_ex held) and re-asserts later.
- ex_branch in WAIT_IF or REDIRECT is ignored.
- Combinational outputs, OR-combined from the sources below:
  - mem_stallreq: stall[3:0]=1111, clear[4]=1.
  - Branch accept cycle (RUN transition): clear[1]=clear[2]=1.
  - WAIT_IF: stall[0]=1, clear[1]=clear[2]=1.
  - REDIRECT: redirect_valid=1, redirect_pc=target, clear[1]=1 (squashes the wrong-path fetch).
  - id_stallreq (RUN, no branch accept): stall[1:0]=11, clear[2]=1.
  - if_stallreq (RUN): stall[0]=1, clear[1]=1.
- In REDIRECT, stall[0]=0 unless mem_stallreq=1. redirect_valid stays high while held.
- redirect_pc equals target in REDIRECT, else RESET_PC.

## Timing
- Reset (async, immediate): state=RUN, target=RESET_PC, counters=0.
- While rst=1: stall=00000, clear=11111, redirect_valid=0, redirect_pc=RESET_PC.
- Branch-to-redirect latency:
  - 1 cycle if IF is idle: accept at T, redirect_valid at T+1.
  - Otherwise 1 cycle after if_stallreq falls.
- Redirect penalty with idle IF: 2 squashed instructions plus 1 redirect cycle.
- Reset mid-WAIT_IF or mid-REDIRECT discards the pending target; no redirect is issued.
- mem_stallreq and ex_branch in the same cycle: stall wins, no latch, state unchanged.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cycles increments each cycle with any stall bit set.
  - flush_count increments on each RUN-state branch acceptance.
  - Both saturate at 32'hFFFF_FFFF. Both reset to 0.
- PIPE_CTRL_PERF_EN undefined: both ports absent; no counter logic.

## Test plan
- rst pulse mid-cycle -> clear=11111 immediately. After release, stall=0, clear=0, redirect_valid=0.
- id_stallreq=1 for 1 cycle in RUN -> stall=00011, clear=00100 that cycle only.
- ex_branch=1, target=32'h0000_0100, IF idle at T:
  - T: clear=00110.
  - T+1: redirect_valid=1, redirect_pc=32'h100, clear=00010.
  - T+2: all outputs zero.
- ex_branch at T with if_stallreq high until T+3:
  - T..T+3: stall[0]=1, clear=00110.
  - T+4: redirect_valid=1.
- ex_branch with mem_stallreq=1 for 2 cycles, then ex_branch again:
  - First two cycles: stall=01111, clear=10000, no latch.
  - Redirect issued one cycle after the third assertion.
- With PIPE_CTRL_PERF_EN: 3 stall cycles + 1 branch -> stall_cycles=3, flush_count=1.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: hazard and redirect controller for the five-stage RV32I pipeline.
// Merges stall requests from IF, ID and MEM with taken-branch notifications
// from EX into per-stage stall/clear enables, and sequences PC redirection,
// holding a redirect back until any in-flight instruction fetch has finished.
// Optional macro PIPE_CTRL_PERF_EN adds the stall_cycles and flush_count
// performance counters (ports and logic both absent when undefined).
module pipe_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_stallreq,
    input  logic        id_stallreq,
    input  logic        mem_stallreq,
    input  logic        ex_branch,
    input  logic [31:0] ex_branch_target,
    output logic [4:0]  stall,
    output logic [4:0]  clear,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_IF  = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] target_reg, target_next;
    logic        branch_accept;

    // A branch is only taken on in RUN and only when MEM is not stalling;
    // otherwise it stays parked in EX and will re-assert later.
    assign branch_accept = (state_reg == RUN) && ex_branch && !mem_stallreq;

    // State and redirect-target registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= RUN;
            target_reg <= RESET_PC;
        end else begin
            state_reg  <= state_next;
            target_reg <= target_next;
        end
    end

    // Next-state logic: latch the target on acceptance, wait for IF if busy.
    always_comb begin
        state_next  = state_reg;
        target_next = target_reg;
        case (state_reg)
            RUN: begin
                if (branch_accept) begin
                    target_next = ex_branch_target;
                    state_next  = if_stallreq ? WAIT_IF : REDIRECT;
                end
            end
            WAIT_IF: begin
                if (!if_stallreq) begin
                    state_next = REDIRECT;
                end
            end
            REDIRECT: begin
                if (!mem_stallreq) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Output logic: each hazard source ORs in its own stall/clear pattern.
    always_comb begin
        stall          = 5'b00000;
        clear          = 5'b00000;
        redirect_valid = 1'b0;
        redirect_pc    = RESET_PC;
        if (rst) begin
            // Bubble every pipeline register while reset is held.
            clear = 5'b11111;
        end else begin
            if (mem_stallreq) begin
                stall = stall | 5'b01111;
                clear = clear | 5'b10000;
            end
            if (branch_accept) begin
                clear = clear | 5'b00110;
            end
            case (state_reg)
                RUN: begin
                    if (id_stallreq && !branch_accept) begin
                        stall = stall | 5'b00011;
                        clear = clear | 5'b00100;
                    end
                    if (if_stallreq) begin
                        stall = stall | 5'b00001;
                        clear = clear | 5'b00010;
                    end
                end
                WAIT_IF: begin
                    stall = stall | 5'b00001;
                    clear = clear | 5'b00110;
                end
                REDIRECT: begin
                    // Squash the wrong-path fetch sitting in if_id.
                    redirect_valid = 1'b1;
                    redirect_pc    = target_reg;
                    clear          = clear | 5'b00010;
                end
                default: begin
                    stall = stall;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles_reg;
    logic [31:0] flush_count_reg;

    // Saturating counters: stalled cycles and accepted redirects.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_reg <= 32'd0;
            flush_count_reg  <= 32'd0;
        end else begin
            if ((|stall) && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            end
            if (branch_accept && (flush_count_reg != 32'hFFFF_FFFF)) begin
                flush_count_reg <= flush_count_reg + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_reg;
    assign flush_count  = flush_count_reg;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        if_stallreq;
    logic        id_stallreq;
    logic        mem_stallreq;
    logic        ex_branch;
    logic [31:0] ex_branch_target;
    logic [4:0]  stall;
    logic [4:0]  clear;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    int total_checks;
    int passed_checks;
    int failed_checks;

    pipe_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .if_stallreq      (if_stallreq),
        .id_stallreq      (id_stallreq),
        .mem_stallreq     (mem_stallreq),
        .ex_branch        (ex_branch),
        .ex_branch_target (ex_branch_target),
        .stall            (stall),
        .clear            (clear),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        assert (got === exp) passed_checks++;
        else begin
            failed_checks++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Check all four primary outputs in one transaction and log it.
    task automatic expect_out(input string tag, input logic [4:0] st, input logic [4:0] cl,
                              input logic rv, input logic [31:0] rpc);
        chk({tag, ".stall"}, {27'd0, stall}, {27'd0, st});
        chk({tag, ".clear"}, {27'd0, clear}, {27'd0, cl});
        chk({tag, ".rv"},    {31'd0, redirect_valid}, {31'd0, rv});
        chk({tag, ".rpc"},   redirect_pc, rpc);
        $display("%0t %s: stall=%b clear=%b rv=%b rpc=%h", $time, tag, stall, clear,
                 redirect_valid, redirect_pc);
    endtask

    // Advance to the next falling edge and apply a new input vector.
    task automatic drive(input logic ifs, input logic ids, input logic mems,
                         input logic br, input logic [31:0] tgt);
        @(negedge clk);
        if_stallreq      = ifs;
        id_stallreq      = ids;
        mem_stallreq     = mems;
        ex_branch        = br;
        ex_branch_target = tgt;
        #1;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        failed_checks = 0;
        rst = 1'b1;
        if_stallreq = 1'b0;
        id_stallreq = 1'b0;
        mem_stallreq = 1'b0;
        ex_branch = 1'b0;
        ex_branch_target = 32'h0;
        #2;
        expect_out("reset_hold", 5'b00000, 5'b11111, 1'b0, 32'h0);

        // Release reset, idle cycle.
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 32'h0);
        expect_out("idle", 5'b00000, 5'b00000, 1'b0, 32'h0);

        // Mid-cycle reset pulse takes effect immediately.
        #2 rst = 1'b1;
        #1;
        expect_out("rst_pulse", 5'b00000, 5'b11111, 1'b0, 32'h0);
        #1 rst = 1'b0;
        drive(0, 0, 0, 0, 32'h0);
        expect_out("post_rst", 5'b00000, 5'b00000, 1'b0, 32'h0);

        // Load-use stall for one cycle.
        drive(0, 1, 0, 0, 32'h0);
        expect_out("id_stall", 5'b00011, 5'b00100, 1'b0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        expect_out("id_stall_end", 5'b00000, 5'b00000, 1'b0, 32'h0);

        // Taken branch with IF idle.
        drive(0, 0, 0, 1, 32'h0000_0100);
        expect_out("br_T", 5'b00000, 5'b00110, 1'b0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        expect_out("br_T1", 5'b00000, 5'b00010, 1'b1, 32'h0000_0100);
        drive(0, 0, 0, 0, 32'h0);
        expect_out("br_T2", 5'b00000, 5'b00000, 1'b0, 32'h0);

        // Taken branch while IF is busy: redirect waits for if_stallreq to fall.
        drive(1, 0, 0, 1, 32'h0000_0200);
        expect_out("brif_T", 5'b00001, 5'b00110, 1'b0, 32'h0);
        drive(1, 0, 0, 0, 32'h0);
        expect_out("brif_T1", 5'b00001, 5'b00110, 1'b0, 32'h0);
        drive(1, 0, 0, 1, 32'h0000_0BAD);
        expect_out("brif_T2", 5'b00001, 5'b00110, 1'b0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        expect_out("brif_T3", 5'b00001, 5'b00110, 1'b0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        expect_out("brif_T4", 5'b00000, 5'b00010, 1'b1, 32'h0000_0200);
        drive(0, 0, 0, 0, 32'h0);
        expect_out("brif_T5", 5'b00000, 5'b00000, 1'b0, 32'h0);

        // Branch blocked by MEM stall, then accepted; REDIRECT held by MEM.
        drive(0, 0, 1, 1, 32'h0000_0300);
        expect_out("brmem_1", 5'b01111, 5'b10000, 1'b0, 32'h0);
        drive(0, 0, 1, 1, 32'h0000_0300);
        expect_out("brmem_2", 5'b01111, 5'b10000, 1'b0, 32'h0);
        drive(0, 0, 0, 1, 32'h0000_0300);
        expect_out("brmem_acc", 5'b00000, 5'b00110, 1'b0, 32'h0);
        drive(0, 0, 1, 0, 32'h0);
        expect_out("redir_mem", 5'b01111, 5'b10010, 1'b1, 32'h0000_0300);
        drive(0, 0, 0, 1, 32'h0000_0400);
        expect_out("redir_ignbr", 5'b00000, 5'b00010, 1'b1, 32'h0000_0300);
        drive(0, 0, 0, 0, 32'h0);
        expect_out("redir_done", 5'b00000, 5'b00000, 1'b0, 32'h0);

        // Reset during WAIT_IF discards the pending redirect.
        drive(1, 0, 0, 1, 32'h0000_0500);
        expect_out("rstw_T", 5'b00001, 5'b00110, 1'b0, 32'h0);
        drive(1, 0, 0, 0, 32'h0);
        expect_out("rstw_wait", 5'b00001, 5'b00110, 1'b0, 32'h0);
        #1 rst = 1'b1;
        #1;
        expect_out("rstw_rst", 5'b00000, 5'b11111, 1'b0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 32'h0);
        expect_out("rstw_after", 5'b00000, 5'b00000, 1'b0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        expect_out("rstw_after2", 5'b00000, 5'b00000, 1'b0, 32'h0);

`ifdef PIPE_CTRL_PERF_EN
        chk("perf_rst_stall", stall_cycles, 32'd0);
        chk("perf_rst_flush", flush_count, 32'd0);
        drive(0, 0, 1, 0, 32'h0);
        drive(0, 1, 0, 0, 32'h0);
        drive(1, 0, 0, 0, 32'h0);
        drive(0, 0, 0, 1, 32'h0000_0600);
        drive(0, 0, 0, 0, 32'h0);
        drive(0, 0, 0, 0, 32'h0);
        chk("perf_stall_cycles", stall_cycles, 32'd3);
        chk("perf_flush_count", flush_count, 32'd1);
        $display("%0t perf: stall_cycles=%0d flush_count=%0d", $time, stall_cycles, flush_count);
`endif

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
